// File: rtl/rr_bus_arbiter16.sv
// rr_bus_arbiter16
//   Round-robin arbiter for 16 requesters sharing one WIDTH-bit result bus.
//   A registered grant drives the select of an internal 16:1 AND-OR mux.
//   Requesters use req/ack. The bus side uses valid/ready.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   Req[15:0]  : per-requester pending flag, held until Ack
//   Din        : flattened data, Din[i*WIDTH +: WIDTH] is requester i
//   Ack[15:0]  : one-hot accept strobe, combinational
//   Grant[15:0]: registered one-hot owner, zero when idle
//   Sel[3:0]   : registered binary owner index (mux select)
//   BusData    : selected Din slice
//   BusValid   : high while a grant is held
//   BusReady   : downstream accept

// Per-lane slice: candidate masking and the AND term of the bus mux.
module rr_bus_arbiter16_lane #(
  parameter int WIDTH = 64
) (
  input  logic             i_req,
  input  logic             i_mask,
  input  logic             i_hit,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_cand,
  output logic [WIDTH-1:0] o_data
);
  assign o_cand = i_req & ~i_mask;
  assign o_data = i_din & {WIDTH{i_hit}};
endmodule

module rr_bus_arbiter16 #(
  parameter int WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         Req,
  input  logic [16*WIDTH-1:0] Din,
  output logic [15:0]         Ack,
  output logic [15:0]         Grant,
  output logic [3:0]          Sel,
  output logic [WIDTH-1:0]    BusData,
  output logic                BusValid,
  input  logic                BusReady
);
  localparam int NUM_LANES = 16;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_grant, w_grant_nxt;
  logic [3:0]  r_sel,   w_sel_nxt;
  logic [3:0]  r_ptr,   w_ptr_nxt;

  logic        w_accept, w_withdraw, w_rearb;
  logic [15:0] w_mask, w_cand;
  logic [3:0]  w_base;
  logic        w_found;
  logic [3:0]  w_win;

  logic [NUM_LANES-1:0][WIDTH-1:0] w_lane_data;

  // First set bit of cand searching base, base+1, ... with 4-bit wrap.
  function automatic logic [4:0] f_pick(input logic [15:0] cand, input logic [3:0] base);
    logic [3:0] idx;
    logic       found;
    logic [3:0] win;
    found = 1'b0;
    win   = 4'd0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = base + 4'(k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  // Bus events in the current cycle
  assign w_accept   = (r_state == S_BUSY) & BusReady;
  assign w_withdraw = (r_state == S_BUSY) & ~BusReady & ~Req[r_sel];
  assign w_rearb    = (r_state == S_IDLE) | w_accept | w_withdraw;

  // On accept, the just-served requester is excluded even though its Req
  // is still high. Search then starts just past it.
  assign w_mask = w_accept ? r_grant : 16'd0;
  assign w_base = w_accept ? (r_sel + 4'd1) : r_ptr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      rr_bus_arbiter16_lane #(.WIDTH(WIDTH)) u_lane (
        .i_req  (Req[gi]),
        .i_mask (w_mask[gi]),
        .i_hit  (r_sel == 4'(gi)),
        .i_din  (Din[gi*WIDTH +: WIDTH]),
        .o_cand (w_cand[gi]),
        .o_data (w_lane_data[gi])
      );
    end
  endgenerate

  assign {w_found, w_win} = f_pick(w_cand, w_base);

  // OR-reduce of the gated lane data completes the 16:1 mux
  always_comb begin
    BusData = '0;
    for (int i = 0; i < NUM_LANES; i++) BusData = BusData | w_lane_data[i];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= 16'd0;
      r_sel   <= 4'd0;
      r_ptr   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state logic.
  // Grant is held under backpressure with no preemption. Pointer moves only
  // on accept, so a withdrawal re-arbitrates from the unchanged pointer.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    if (w_accept) w_ptr_nxt = r_sel + 4'd1;
    if (w_rearb) begin
      if (w_found) begin
        w_state_nxt = S_BUSY;
        w_grant_nxt = 16'd1 << w_win;
        w_sel_nxt   = w_win;
      end else begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 16'd0;
        w_sel_nxt   = 4'd0;
      end
    end
  end

  // Outputs
  always_comb begin
    BusValid = (r_state == S_BUSY);
    Grant    = r_grant;
    Sel      = r_sel;
    Ack      = r_grant & {16{BusValid & BusReady}};
  end

endmodule

// File: tb/tb_rr_bus_arbiter16.sv
module tb_rr_bus_arbiter16;
  localparam int WIDTH = 64;

  logic                clk;
  logic                rst_n;
  logic [15:0]         Req;
  logic [16*WIDTH-1:0] Din;
  logic [15:0]         Ack;
  logic [15:0]         Grant;
  logic [3:0]          Sel;
  logic [WIDTH-1:0]    BusData;
  logic                BusValid;
  logic                BusReady;

  int checks = 0;
  int errors = 0;

  rr_bus_arbiter16 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Req      (Req),
    .Din      (Din),
    .Ack      (Ack),
    .Grant    (Grant),
    .Sel      (Sel),
    .BusData  (BusData),
    .BusValid (BusValid),
    .BusReady (BusReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per cycle: inputs applied this cycle, outputs expected this cycle
  typedef struct {
    logic        rst_n;
    logic [15:0] req;
    logic        rdy;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        valid;
    logic [15:0] ack;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [15:0] q, input logic y,
                     input logic [15:0] g, input logic [3:0] s, input logic v,
                     input logic [15:0] a);
    vec_t t;
    t.rst_n = r; t.req = q; t.rdy = y;
    t.grant = g; t.sel = s; t.valid = v; t.ack = a;
    tv.push_back(t);
  endtask

  function automatic logic [WIDTH-1:0] din_of(input logic [3:0] i);
    return 64'hDEAD_BEEF_0000_0000 | 64'(i);
  endfunction

  task automatic chk(input string nm, input int row, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  // Drive at the falling edge, compare 1ns later; the rising edge commits state
  task automatic apply(input logic r, input logic [15:0] q, input logic y);
    @(negedge clk);
    rst_n = r; Req = q; BusReady = y;
    #1;
  endtask

  task automatic check_outs(input int row, input logic [15:0] g, input logic [3:0] s,
                            input logic v, input logic [15:0] a);
    chk("grant",    row, 64'(Grant),    64'(g));
    chk("sel",      row, 64'(Sel),      64'(s));
    chk("busvalid", row, 64'(BusValid), 64'(v));
    chk("ack",      row, 64'(Ack),      64'(a));
    chk("busdata",  row, BusData,       din_of(s));
  endtask

  initial begin
    logic [15:0] seen;
    for (int i = 0; i < 16; i++) Din[i*WIDTH +: WIDTH] = din_of(4'(i));
    rst_n = 1'b0; Req = 16'hFFFF; BusReady = 1'b0;
    @(posedge clk);

    //    rst  req      rdy   grant    sel valid ack
    // reset held two cycles with all requesting, then release
    add(0, 16'hFFFF, 0,   16'h0000, 0, 0, 16'h0000);
    add(0, 16'hFFFF, 0,   16'h0000, 0, 0, 16'h0000);
    add(1, 16'hFFFF, 0,   16'h0000, 0, 0, 16'h0000);
    add(1, 16'hFFFF, 0,   16'h0001, 0, 1, 16'h0000);
    add(0, 16'h0000, 0,   16'h0001, 0, 1, 16'h0000);
    // single request from 5, accepted, then idle with Ptr=6
    add(1, 16'h0020, 0,   16'h0000, 0, 0, 16'h0000);
    add(1, 16'h0020, 0,   16'h0020, 5, 1, 16'h0000);
    add(1, 16'h0020, 1,   16'h0020, 5, 1, 16'h0020);
    add(1, 16'h0000, 1,   16'h0000, 0, 0, 16'h0000);
    // Ptr=6: search 6..15,0.. finds 0 before 5; 5 follows back-to-back
    add(1, 16'h0021, 0,   16'h0000, 0, 0, 16'h0000);
    add(1, 16'h0021, 1,   16'h0001, 0, 1, 16'h0001);
    add(1, 16'h0020, 1,   16'h0020, 5, 1, 16'h0020);
    add(0, 16'h0000, 0,   16'h0000, 0, 0, 16'h0000);
    // backpressure: 0 held for 5 stalled cycles, then 3 with no gap
    add(1, 16'h0009, 0,   16'h0000, 0, 0, 16'h0000);
    for (int k = 0; k < 5; k++)
      add(1, 16'h0009, 0, 16'h0001, 0, 1, 16'h0000);
    add(1, 16'h0009, 1,   16'h0001, 0, 1, 16'h0001);
    add(1, 16'h0008, 0,   16'h0008, 3, 1, 16'h0000);
    add(1, 16'h0008, 1,   16'h0008, 3, 1, 16'h0008);
    // withdrawal: Ptr=4, 2 granted (search from 4 hits 4 first, so use 2|4)
    add(1, 16'h0000, 0,   16'h0000, 0, 0, 16'h0000);
    // reset to Ptr=0 so requester 2 wins over 4
    add(0, 16'h0000, 0,   16'h0000, 0, 0, 16'h0000);
    add(1, 16'h0014, 0,   16'h0000, 0, 0, 16'h0000);
    add(1, 16'h0014, 0,   16'h0004, 2, 1, 16'h0000);
    add(1, 16'h0010, 0,   16'h0004, 2, 1, 16'h0000);
    add(1, 16'h0010, 0,   16'h0010, 4, 1, 16'h0000);
    add(1, 16'h0010, 1,   16'h0010, 4, 1, 16'h0010);
    // Ptr now 5; 7 granted, reset mid-transfer, re-granted after release
    add(1, 16'h0080, 0,   16'h0000, 0, 0, 16'h0000);
    add(1, 16'h0080, 0,   16'h0080, 7, 1, 16'h0000);
    add(0, 16'h0080, 0,   16'h0080, 7, 1, 16'h0000);
    add(1, 16'h0080, 0,   16'h0000, 0, 0, 16'h0000);
    add(1, 16'h0080, 0,   16'h0080, 7, 1, 16'h0000);
    add(0, 16'hFFFF, 0,   16'h0080, 7, 1, 16'h0000);
    add(1, 16'hFFFF, 1,   16'h0000, 0, 0, 16'h0000);

    foreach (tv[i]) begin
      apply(tv[i].rst_n, tv[i].req, tv[i].rdy);
      check_outs(i, tv[i].grant, tv[i].sel, tv[i].valid, tv[i].ack);
    end

    // Fairness: all requesting, ready every cycle, grants rotate 0..15,0..3
    seen = 16'h0000;
    for (int k = 0; k < 20; k++) begin
      apply(1'b1, 16'hFFFF, 1'b1);
      check_outs(100 + k, 16'd1 << (k % 16), 4'(k % 16), 1'b1, 16'd1 << (k % 16));
      if (k < 16) begin
        chk("ack_repeat", 100 + k, 64'((seen & Ack) != 16'h0000), 64'd0);
        seen = seen | Ack;
      end
    end
    chk("ack_all_once", 200, 64'(seen), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
